kbd_focus_arbiter: RTL and testbench

Shares the single PS/2 scancode stream between up to four keyboard input controllers (loop count, tempo, step edit, pattern select). Function-key hotkeys pick one controller to hold focus. The arbiter drives that controller's Enable and forwards scancodes only to it. It sits between the PS/2 receiver and the input controllers and owns prefix/break decoding, so hotkeys never leak into a controller.

---
 rtl/ps2_keys_pkg.sv | 78 +++++++
 rtl/focus_idle_timer.sv | 31 +++
 rtl/kbd_focus_arbiter.sv | 150 +++++++++++++++
 tb/tb_kbd_focus_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_keys_pkg.sv
// Shared PS/2 set-2 scancode constants and decode helpers for the keyboard
// input controllers and the focus arbiter.
package ps2_keys_pkg;

    localparam logic [7:0] KEY_0         = 8'h45;
    localparam logic [7:0] KEY_1         = 8'h16;
    localparam logic [7:0] KEY_2         = 8'h1E;
    localparam logic [7:0] KEY_3         = 8'h26;
    localparam logic [7:0] KEY_4         = 8'h25;
    localparam logic [7:0] KEY_5         = 8'h2E;
    localparam logic [7:0] KEY_6         = 8'h36;
    localparam logic [7:0] KEY_7         = 8'h3D;
    localparam logic [7:0] KEY_8         = 8'h3E;
    localparam logic [7:0] KEY_9         = 8'h46;
    localparam logic [7:0] KEY_ENTER     = 8'h5A;
    localparam logic [7:0] KEY_BACKSPACE = 8'h66;
    localparam logic [7:0] KEY_RELEASE   = 8'hF0;
    localparam logic [7:0] KEY_EXTEND    = 8'hE0;
    localparam logic [7:0] KEY_F1        = 8'h05;
    localparam logic [7:0] KEY_F2        = 8'h06;
    localparam logic [7:0] KEY_F3        = 8'h04;
    localparam logic [7:0] KEY_F4        = 8'h0C;
    localparam logic [7:0] KEY_ESC       = 8'h76;
    localparam logic [7:0] KEY_TAB       = 8'h0D;

    typedef enum logic [1:0] {
        HK_NONE,
        HK_FKEY,
        HK_ESC,
        HK_TAB
    } hotkey_e;

    typedef struct packed {
        hotkey_e    kind;
        logic [1:0] index;
    } hotkey_t;

    function automatic logic isDigit(input logic [7:0] code);
        case (code)
            KEY_0, KEY_1, KEY_2, KEY_3, KEY_4,
            KEY_5, KEY_6, KEY_7, KEY_8, KEY_9: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    // Returns 0 for non-digit codes; pair with isDigit.
    function automatic logic [3:0] decodeDigit(input logic [7:0] code);
        case (code)
            KEY_1:   return 4'd1;
            KEY_2:   return 4'd2;
            KEY_3:   return 4'd3;
            KEY_4:   return 4'd4;
            KEY_5:   return 4'd5;
            KEY_6:   return 4'd6;
            KEY_7:   return 4'd7;
            KEY_8:   return 4'd8;
            KEY_9:   return 4'd9;
            default: return 4'd0;
        endcase
    endfunction

    function automatic hotkey_t classifyHotkey(input logic [7:0] code);
        hotkey_t hk;
        hk.kind  = HK_NONE;
        hk.index = 2'd0;
        case (code)
            KEY_F1:  begin hk.kind = HK_FKEY; hk.index = 2'd0; end
            KEY_F2:  begin hk.kind = HK_FKEY; hk.index = 2'd1; end
            KEY_F3:  begin hk.kind = HK_FKEY; hk.index = 2'd2; end
            KEY_F4:  begin hk.kind = HK_FKEY; hk.index = 2'd3; end
            KEY_ESC: hk.kind = HK_ESC;
            KEY_TAB: hk.kind = HK_TAB;
            default: hk.kind = HK_NONE;
        endcase
        return hk;
    endfunction

endpackage

// File: rtl/focus_idle_timer.sv
// Idle counter for focus auto-release: counts while running, reloads to 0 on
// activity, and flags expiry in the cycle the count sits at TIMEOUT_CYCLES-1.
module focus_idle_timer #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic Clock,
    input  logic nReset,
    input  logic run,
    input  logic reload,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;

    // Activity in the terminal cycle suppresses expiry so the byte keeps focus.
    assign expire = run && !reload && (count_q == TERMINAL);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            count_q <= '0;
        end else if (!run || reload) begin
            count_q <= '0;
        end else if (count_q != TERMINAL) begin
            count_q <= count_q + CW'(1);
        end
    end

endmodule

// File: rtl/kbd_focus_arbiter.sv
// Routes the PS/2 scancode stream to one focused input controller; F-key, ESC
// and TAB hotkeys pick focus. Define FOCUS_TIMEOUT_EN for idle auto-release.
//
// state  | meaning
// NORM   | expecting a make code; only here can a byte be a hotkey
// BRK    | F0 seen, next byte is a break code
// EXT    | E0 seen, next byte is an extended code or F0
// EXTBRK | E0 F0 seen, next byte is an extended break code
module kbd_focus_arbiter
    import ps2_keys_pkg::*;
#(
    parameter int N_TARGETS      = 4,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic [7:0]           data,
    input  logic                 data_en,
    input  logic                 Lock,
    output logic [7:0]           fwd_data,
    output logic [N_TARGETS-1:0] fwd_en,
    output logic [N_TARGETS-1:0] Enable,
    output logic                 FocusValid,
    output logic [1:0]           Focus
);

    typedef enum logic [1:0] {
        NORM,
        BRK,
        EXT,
        EXTBRK
    } parse_state_e;

    localparam logic [1:0]           LAST_IDX = 2'(N_TARGETS - 1);
    localparam logic [N_TARGETS-1:0] ONE      = N_TARGETS'(1);

    parse_state_e state_q, state_d;
    logic         focus_valid_q, focus_valid_d;
    logic [1:0]   focus_idx_q, focus_idx_d;
    hotkey_t      hk;
    logic         hotkey_byte;
    logic         consume;
    logic         forward;
    logic         idle_expire;

    assign hk          = classifyHotkey(data);
    assign hotkey_byte = (state_q == NORM) && (hk.kind != HK_NONE);
    assign consume     = data_en && hotkey_byte;
    assign forward     = data_en && !hotkey_byte && focus_valid_q;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= NORM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (data_en) begin
            unique case (state_q)
                NORM: begin
                    if (data == KEY_RELEASE)     state_d = BRK;
                    else if (data == KEY_EXTEND) state_d = EXT;
                    else                         state_d = NORM;
                end
                EXT:     state_d = (data == KEY_RELEASE) ? EXTBRK : NORM;
                BRK:     state_d = NORM;
                EXTBRK:  state_d = NORM;
                default: state_d = NORM;
            endcase
        end
    end

    // Hotkeys are swallowed even while locked; Lock only blocks the action.
    always_comb begin
        focus_valid_d = focus_valid_q;
        focus_idx_d   = focus_idx_q;
        if (consume && !Lock) begin
            case (hk.kind)
                HK_FKEY: begin
                    if (int'(hk.index) < N_TARGETS) begin
                        focus_valid_d = 1'b1;
                        focus_idx_d   = hk.index;
                    end
                end
                HK_ESC: begin
                    focus_valid_d = 1'b0;
                    focus_idx_d   = 2'd0;
                end
                HK_TAB: begin
                    focus_valid_d = 1'b1;
                    if (!focus_valid_q || focus_idx_q == LAST_IDX)
                        focus_idx_d = 2'd0;
                    else
                        focus_idx_d = focus_idx_q + 2'd1;
                end
                default: ;
            endcase
        end else if (idle_expire) begin
            focus_valid_d = 1'b0;
            focus_idx_d   = 2'd0;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            focus_valid_q <= 1'b0;
            focus_idx_q   <= 2'd0;
        end else begin
            focus_valid_q <= focus_valid_d;
            focus_idx_q   <= focus_idx_d;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            fwd_en   <= '0;
            fwd_data <= 8'h00;
        end else begin
            fwd_en <= '0;
            if (forward) begin
                fwd_en   <= ONE << focus_idx_q;
                fwd_data <= data;
            end
        end
    end

`ifdef FOCUS_TIMEOUT_EN
    focus_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .Clock  (Clock),
        .nReset (nReset),
        .run    (focus_valid_q && !Lock),
        .reload (data_en),
        .expire (idle_expire)
    );
`else
    logic unused_timeout;
    assign idle_expire    = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    assign Enable     = focus_valid_q ? (ONE << focus_idx_q) : '0;
    assign FocusValid = focus_valid_q;
    assign Focus      = focus_idx_q;

endmodule

// File: tb/tb_kbd_focus_arbiter.sv
// Scoreboard bench for kbd_focus_arbiter with three targets; forwarded bytes
// are queued with their due cycle and matched against fwd_en/fwd_data.
module tb_kbd_focus_arbiter;

    localparam int NT = 3;
    localparam int TO = 8;

    logic          Clock = 1'b0;
    logic          nReset = 1'b0;
    logic [7:0]    data = 8'h00;
    logic          data_en = 1'b0;
    logic          Lock = 1'b0;
    logic [7:0]    fwd_data;
    logic [NT-1:0] fwd_en;
    logic [NT-1:0] Enable;
    logic          FocusValid;
    logic [1:0]    Focus;

    kbd_focus_arbiter #(
        .N_TARGETS(NT),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .Clock      (Clock),
        .nReset     (nReset),
        .data       (data),
        .data_en    (data_en),
        .Lock       (Lock),
        .fwd_data   (fwd_data),
        .fwd_en     (fwd_en),
        .Enable     (Enable),
        .FocusValid (FocusValid),
        .Focus      (Focus)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [NT-1:0] en;
        logic [7:0]    data;
        int            due;
    } fwd_t;

    fwd_t       fwd_q[$];
    fwd_t       mon_e;
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         m_st = 0;
    bit         m_valid = 1'b0;
    int         m_idx = 0;
    logic [7:0] m_last = 8'h00;
    bit         mon_on = 1'b0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [NT-1:0] onehot(input int i);
        logic [NT-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    always @(posedge Clock) begin
        #1;
        if (mon_on) begin
            if (fwd_q.size() > 0 && fwd_q[0].due == cyc) begin
                mon_e = fwd_q.pop_front();
                check_eq("fwd_en", 32'(fwd_en), 32'(mon_e.en));
                check_eq("fwd_data", 32'(fwd_data), 32'(mon_e.data));
                m_last = mon_e.data;
            end else begin
                check_eq("fwd_idle_en", 32'(fwd_en), 32'd0);
                check_eq("fwd_hold_data", 32'(fwd_data), 32'(m_last));
            end
        end
    end

    task automatic check_focus(input string tag);
        check_eq({tag, "_enable"}, 32'(Enable), m_valid ? 32'(onehot(m_idx)) : 32'd0);
        check_eq({tag, "_valid"}, 32'(FocusValid), 32'(m_valid));
        check_eq({tag, "_focus"}, 32'(Focus), m_valid ? 32'(m_idx) : 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clock);
    endtask

    // Called at a falling edge; drives one byte and updates the model.
    task automatic send_byte(input logic [7:0] b);
        bit hot;
        int k;
        hot = (m_st == 0) && (b inside {8'h05, 8'h06, 8'h04, 8'h0C, 8'h76, 8'h0D});
        data    = b;
        data_en = 1'b1;
        if (!hot && m_valid) fwd_q.push_back('{onehot(m_idx), b, cyc + 1});
        case (m_st)
            0:       m_st = (b == 8'hF0) ? 1 : ((b == 8'hE0) ? 2 : 0);
            2:       m_st = (b == 8'hF0) ? 3 : 0;
            default: m_st = 0;
        endcase
        if (hot && !Lock) begin
            if (b == 8'h76) begin
                m_valid = 1'b0;
                m_idx   = 0;
            end else if (b == 8'h0D) begin
                m_idx   = m_valid ? (m_idx + 1) % NT : 0;
                m_valid = 1'b1;
            end else begin
                k = (b == 8'h05) ? 0 : (b == 8'h06) ? 1 : (b == 8'h04) ? 2 : 3;
                if (k < NT) begin
                    m_valid = 1'b1;
                    m_idx   = k;
                end
            end
        end
        @(negedge Clock);
        data_en = 1'b0;
        check_focus($sformatf("byte_%02h", b));
    endtask

    task automatic do_reset();
        nReset  = 1'b0;
        m_st    = 0;
        m_valid = 1'b0;
        m_idx   = 0;
        m_last  = 8'h00;
        #2;
        check_eq("rst_fwd_en", 32'(fwd_en), 32'd0);
        check_eq("rst_fwd_data", 32'(fwd_data), 32'd0);
        check_focus("rst");
        idle(2);
        nReset = 1'b1;
    endtask

    logic [7:0] pool [13] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h76, 8'h0D,
                              8'hF0, 8'hE0, 8'h16, 8'h1E, 8'h26, 8'h5A, 8'h66};

    initial begin
        idle(1);
        do_reset();
        mon_on = 1'b1;

        // No focus: dropped, then F1 takes focus without being forwarded
        send_byte(8'h16);
        send_byte(8'h05);
        send_byte(8'h16);
        send_byte(8'hF0);
        send_byte(8'h16);
        // Hotkey codes behind prefixes are forwarded and do not move focus
        send_byte(8'hF0);
        send_byte(8'h05);
        send_byte(8'hE0);
        send_byte(8'h05);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h05);
        // F4 is out of range with three targets
        send_byte(8'h0C);
        send_byte(8'h04);
        send_byte(8'h0D);
        send_byte(8'h0D);
        send_byte(8'h1E);
        // Lock blocks hotkey actions, not forwarding
        Lock = 1'b1;
        send_byte(8'h04);
        send_byte(8'h76);
        send_byte(8'h26);
        Lock = 1'b0;
        send_byte(8'h04);
        send_byte(8'h06);
        send_byte(8'h16);
        send_byte(8'h76);
        send_byte(8'h2E);
        send_byte(8'h0D);
        send_byte(8'h0D);
        send_byte(8'h0D);
        send_byte(8'h0D);
        // Reset after a prefix must leave the parser in NORM
        send_byte(8'hF0);
        do_reset();
        send_byte(8'h05);

`ifdef FOCUS_TIMEOUT_EN
        idle(7);
        check_focus("to_before_expiry");
        idle(1);
        m_valid = 1'b0;
        m_idx   = 0;
        check_focus("to_expired");
        send_byte(8'h05);
        idle(7);
        send_byte(8'h16);
        Lock = 1'b1;
        idle(20);
        check_focus("to_locked_hold");
        Lock = 1'b0;
        idle(7);
        check_focus("to_unlock_before");
        idle(1);
        m_valid = 1'b0;
        m_idx   = 0;
        check_focus("to_unlock_expired");
`else
        idle(100);
        check_focus("no_timeout_hold");
`endif

        for (int i = 0; i < 80; i++) begin
            Lock = ($urandom_range(0, 3) == 0);
            send_byte(pool[$urandom_range(0, 12)]);
            idle($urandom_range(0, 2));
        end
        Lock = 1'b0;

        idle(3);
        check_eq("fwd_queue_drained", 32'(fwd_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

endmodule
